// File: rtl/elastic_buffer_if.sv
// Valid/ready stream bundle: payload, valid from the producer, ready from the consumer.
// Latency: none, wires only.
// Backpressure: consumer drives rdy; a beat moves on an edge where vld & rdy.
// Ports (modports):
//   master : drives dat, vld; samples rdy
//   slave  : samples dat, vld; drives rdy
interface elastic_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] dat;
   logic                  vld;
   logic                  rdy;

   modport master (output dat, output vld, input rdy);
   modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/elastic_buffer.sv
// DEPTH-entry valid/ready elastic buffer with occupancy count, sync flush, almost-full.
// Latency: 1 cycle from accept into an empty buffer to o_data valid; no pass-through.
// Backpressure: registered ready, drops only at DEPTH entries; no comb path rdy->rdy.
// Ports:
//   i_clock, i_aresetn : rising-edge clock, asynchronous active-low reset
//   i_flush            : synchronous discard of all entries (wins over handshakes)
//   s_in  (slave)      : upstream dat/vld in, rdy out (registered)
//   m_out (master)     : downstream dat/vld out (registered), rdy in
//   o_count            : entries held (registered)
//   o_almost_full      : o_count >= AFULL_LEVEL (registered)
module elastic_buffer #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int AFULL_LEVEL = 3
) (
   input  logic                       i_clock,
   input  logic                       i_aresetn,
   input  logic                       i_flush,
   elastic_buffer_if.slave            s_in,
   elastic_buffer_if.master           m_out,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_almost_full
);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [CNT_W-1:0]      count_q, count_n;
   logic [DATA_WIDTH-1:0] data_q, data_n;
   logic                  in_rdy_q, out_vld_q, afull_q;
   logic                  acc, tx;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign acc = s_in.vld & in_rdy_q;
   assign tx  = out_vld_q & m_out.rdy;

   always_comb begin
      count_n  = count_q;
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      data_n   = data_q;
      if (i_flush) begin
         // o_data is left alone: it is don't-care while valid is low.
         count_n  = '0;
         wr_ptr_n = '0;
         rd_ptr_n = '0;
      end else begin
         if (acc) wr_ptr_n = ptr_inc(wr_ptr);
         if (tx)  rd_ptr_n = ptr_inc(rd_ptr);
         if (acc && !tx)
            count_n = count_q + CNT_W'(1);
         else if (!acc && tx)
            count_n = count_q - CNT_W'(1);
         // The new head equals the write slot only when the buffer would otherwise
         // be empty (a full buffer cannot accept), so forward the incoming word.
         if (acc && (wr_ptr == rd_ptr_n))
            data_n = s_in.dat;
         else if (tx)
            data_n = mem[rd_ptr_n];
      end
   end

   always_ff @(posedge i_clock or negedge i_aresetn) begin
      if (!i_aresetn) begin
         count_q   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         data_q    <= '0;
         in_rdy_q  <= 1'b0;
         out_vld_q <= 1'b0;
         afull_q   <= 1'b0;
      end else begin
         count_q   <= count_n;
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         data_q    <= data_n;
         in_rdy_q  <= (count_n != CNT_W'(DEPTH));
         out_vld_q <= (count_n != '0);
         afull_q   <= (count_n >= CNT_W'(AFULL_LEVEL));
      end
   end

   // Storage carries no reset; it is written only on a real accept.
   always_ff @(posedge i_clock) begin
      if (acc && !i_flush)
         mem[wr_ptr] <= s_in.dat;
   end

   assign s_in.rdy      = in_rdy_q;
   assign m_out.dat     = data_q;
   assign m_out.vld     = out_vld_q;
   assign o_count       = count_q;
   assign o_almost_full = afull_q;
endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: three instances (DEPTH 4/5/2) share one stimulus stream.
// Directed scenarios target the DEPTH=4 instance; the random run checks all three.
// A per-instance queue scoreboard and count model produce every expected value.
module tb_elastic_buffer;
   logic        clk = 1'b0;
   logic        arstn = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] in_dat = '0;
   logic        in_vld = 1'b0;
   logic        out_rdy = 1'b0;

   always #5 clk = ~clk;

   elastic_buffer_if #(.DATA_WIDTH(32)) up0 ();
   elastic_buffer_if #(.DATA_WIDTH(32)) dn0 ();
   elastic_buffer_if #(.DATA_WIDTH(32)) up1 ();
   elastic_buffer_if #(.DATA_WIDTH(32)) dn1 ();
   elastic_buffer_if #(.DATA_WIDTH(32)) up2 ();
   elastic_buffer_if #(.DATA_WIDTH(32)) dn2 ();

   assign up0.dat = in_dat;  assign up0.vld = in_vld;  assign dn0.rdy = out_rdy;
   assign up1.dat = in_dat;  assign up1.vld = in_vld;  assign dn1.rdy = out_rdy;
   assign up2.dat = in_dat;  assign up2.vld = in_vld;  assign dn2.rdy = out_rdy;

   logic [2:0] cnt0, cnt1;
   logic [1:0] cnt2;
   logic       af0, af1, af2;

   elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .AFULL_LEVEL(3)) u_dut0 (
      .i_clock(clk), .i_aresetn(arstn), .i_flush(flush),
      .s_in(up0), .m_out(dn0), .o_count(cnt0), .o_almost_full(af0));
   elastic_buffer #(.DATA_WIDTH(32), .DEPTH(5), .AFULL_LEVEL(4)) u_dut1 (
      .i_clock(clk), .i_aresetn(arstn), .i_flush(flush),
      .s_in(up1), .m_out(dn1), .o_count(cnt1), .o_almost_full(af1));
   elastic_buffer #(.DATA_WIDTH(32), .DEPTH(2), .AFULL_LEVEL(2)) u_dut2 (
      .i_clock(clk), .i_aresetn(arstn), .i_flush(flush),
      .s_in(up2), .m_out(dn2), .o_count(cnt2), .o_almost_full(af2));

   logic [31:0] o_dat [3];
   logic [3:0]  o_cnt [3];
   logic [2:0]  o_irdy, o_ovld, o_af;
   assign o_dat  = '{dn0.dat, dn1.dat, dn2.dat};
   assign o_cnt  = '{4'(cnt0), 4'(cnt1), 4'(cnt2)};
   assign o_irdy = {up2.rdy, up1.rdy, up0.rdy};
   assign o_ovld = {dn2.vld, dn1.vld, dn0.vld};
   assign o_af   = {af2, af1, af0};

   int depth [3];
   int afl   [3];
   int mcnt  [3];
   logic [31:0] sb [3][$];
   bit          tx_flag  [3];
   bit          tx_empty [3];
   logic [31:0] got_dat  [3];
   logic [31:0] exp_dat  [3];

   int nvec = 0;
   int nmis = 0;

   // Model one edge: push on accept, pop on transmit, then advance to posedge+1.
   task automatic tick();
      for (int k = 0; k < 3; k++) begin
         bit acc, tx;
         acc = in_vld && o_irdy[k];
         tx  = o_ovld[k] && out_rdy;
         tx_flag[k]  = 1'b0;
         tx_empty[k] = 1'b0;
         if (flush) begin
            sb[k].delete();
            mcnt[k] = 0;
         end else begin
            if (tx) begin
               tx_flag[k] = 1'b1;
               got_dat[k] = o_dat[k];
               if (sb[k].size() == 0) tx_empty[k] = 1'b1;
               else exp_dat[k] = sb[k].pop_front();
            end
            if (acc) sb[k].push_back(in_dat);
            mcnt[k] = mcnt[k] + int'(acc) - int'(tx);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int k = 0; k < 3; k++) begin
         sb[k].delete();
         mcnt[k] = 0;
      end
   endtask

   task automatic test_reset();
      arstn = 1'b0; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_dat = '0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         nvec++;
         if ({o_irdy[0], o_ovld[0], o_af[0], o_cnt[0], o_dat[0]} !== 39'd0) begin
            nmis++;
            $display("FAIL reset_hold got rdy=%b vld=%b af=%b cnt=%0d dat=%h want all 0",
                     o_irdy[0], o_ovld[0], o_af[0], o_cnt[0], o_dat[0]);
         end
      end
      arstn = 1'b1;
      clear_model();
      tick();
      nvec++;
      if ({o_irdy[0], o_ovld[0], o_af[0], o_cnt[0]} !== {3'b100, 4'd0}) begin
         nmis++;
         $display("FAIL reset_release got rdy=%b vld=%b af=%b cnt=%0d want rdy=1 vld=0 af=0 cnt=0",
                  o_irdy[0], o_ovld[0], o_af[0], o_cnt[0]);
      end
   endtask

   task automatic test_fill();
      out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [6:0] want;
         in_vld = 1'b1;
         in_dat = 32'hA0 + 32'(i);
         tick();
         want = {(i != 3), 1'b1, (i >= 2), 4'(i + 1)};
         nvec++;
         if ({o_irdy[0], o_ovld[0], o_af[0], o_cnt[0]} !== want) begin
            nmis++;
            $display("FAIL fill_flags[%0d] got %b want %b", i,
                     {o_irdy[0], o_ovld[0], o_af[0], o_cnt[0]}, want);
         end
         nvec++;
         if (o_dat[0] !== 32'hA0) begin
            nmis++;
            $display("FAIL fill_head[%0d] got %h want a0", i, o_dat[0]);
         end
      end
      in_vld = 1'b0;
   endtask

   task automatic test_drain();
      out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_vld = 1'b1;
         in_dat = 32'hA4 + 32'(i);
         tick();
         nvec++;
         if (!tx_flag[0] || got_dat[0] !== 32'hA0 + 32'(i)) begin
            nmis++;
            $display("FAIL drain_order[%0d] got tx=%b dat=%h want tx=1 dat=%h",
                     i, tx_flag[0], got_dat[0], 32'hA0 + 32'(i));
         end
         nvec++;
         if (tx_empty[0] || got_dat[0] !== exp_dat[0]) begin
            nmis++;
            $display("FAIL drain_sb[%0d] got %h want %h", i, got_dat[0], exp_dat[0]);
         end
         if (i == 0) begin
            nvec++;
            if ({o_irdy[0], o_ovld[0], o_af[0], o_cnt[0]} !== {3'b111, 4'd3}) begin
               nmis++;
               $display("FAIL drain_ready_back got %b want 1113",
                        {o_irdy[0], o_ovld[0], o_af[0], o_cnt[0]});
            end
         end
      end
      in_vld = 1'b0;
      for (int c = 0; c < 10 && o_ovld[0]; c++) begin
         tick();
         if (tx_flag[0]) begin
            nvec++;
            if (tx_empty[0] || got_dat[0] !== exp_dat[0]) begin
               nmis++;
               $display("FAIL drain_tail got %h want %h", got_dat[0], exp_dat[0]);
            end
         end
      end
      nvec++;
      if ({o_irdy[0], o_ovld[0], o_cnt[0]} !== {2'b10, 4'd0} || sb[0].size() != 0) begin
         nmis++;
         $display("FAIL drain_empty got rdy=%b vld=%b cnt=%0d left=%0d want 1 0 0 0",
                  o_irdy[0], o_ovld[0], o_cnt[0], sb[0].size());
      end
   endtask

   task automatic test_stream();
      int outs = 0;
      out_rdy = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         in_vld = (i < 100);
         in_dat = 32'(i);
         tick();
         if (tx_flag[0]) begin
            nvec++;
            if (tx_empty[0] || got_dat[0] !== exp_dat[0] || got_dat[0] !== 32'(outs)) begin
               nmis++;
               $display("FAIL stream_data got %h want %h", got_dat[0], 32'(outs));
            end
            outs++;
         end
         if (i < 100) begin
            nvec++;
            if ({o_irdy[0], o_ovld[0], o_cnt[0]} !== {2'b11, 4'd1}) begin
               nmis++;
               $display("FAIL stream_flags[%0d] got rdy=%b vld=%b cnt=%0d want 1 1 1",
                        i, o_irdy[0], o_ovld[0], o_cnt[0]);
            end
         end
      end
      nvec++;
      if (outs != 100) begin
         nmis++;
         $display("FAIL stream_count got %0d words want 100", outs);
      end
      in_vld = 1'b0;
   endtask

   task automatic test_flush();
      out_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_vld = 1'b1;
         in_dat = 32'hB0 + 32'(i);
         tick();
      end
      nvec++;
      if (o_cnt[0] !== 4'd2) begin
         nmis++;
         $display("FAIL flush_prefill got cnt=%0d want 2", o_cnt[0]);
      end
      in_dat = 32'hB2;
      flush  = 1'b1;
      tick();
      flush  = 1'b0;
      nvec++;
      if ({o_irdy[0], o_ovld[0], o_af[0], o_cnt[0]} !== {3'b100, 4'd0}) begin
         nmis++;
         $display("FAIL flush_flags got %b want 1000000",
                  {o_irdy[0], o_ovld[0], o_af[0], o_cnt[0]});
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if (tx_flag[0] || o_ovld[0] !== 1'b0) begin
            nmis++;
            $display("FAIL flush_no_b2 got tx=%b vld=%b want 0 0", tx_flag[0], o_ovld[0]);
         end
      end
   endtask

   task automatic test_random();
      flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         bit slow_sink;
         if (c == 3000 || c == 7000) begin
            arstn = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
               nvec++;
               if ({o_irdy[k], o_ovld[k], o_af[k], o_cnt[k], o_dat[k]} !== 39'd0) begin
                  nmis++;
                  $display("FAIL rand_async_reset dut%0d got rdy=%b vld=%b cnt=%0d dat=%h want 0",
                           k, o_irdy[k], o_ovld[k], o_cnt[k], o_dat[k]);
               end
            end
            @(posedge clk); #1;
            arstn = 1'b1;
            clear_model();
         end
         slow_sink = ((c / 400) % 2) == 1;
         in_vld  = ($urandom_range(0, 3) != 0);
         out_rdy = slow_sink ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
         in_dat  = $urandom();
         flush   = ($urandom_range(0, 127) == 0);
         tick();
         for (int k = 0; k < 3; k++) begin
            logic [6:0] want;
            if (tx_flag[k]) begin
               nvec++;
               if (tx_empty[k] || got_dat[k] !== exp_dat[k]) begin
                  nmis++;
                  $display("FAIL rand_sb dut%0d cyc %0d got %h want %h empty=%b",
                           k, c, got_dat[k], exp_dat[k], tx_empty[k]);
               end
            end
            want = {(mcnt[k] != depth[k]), (mcnt[k] != 0), (mcnt[k] >= afl[k]), 4'(mcnt[k])};
            nvec++;
            if ({o_irdy[k], o_ovld[k], o_af[k], o_cnt[k]} !== want) begin
               nmis++;
               $display("FAIL rand_flags dut%0d cyc %0d got %b want %b",
                        k, c, {o_irdy[k], o_ovld[k], o_af[k], o_cnt[k]}, want);
            end
         end
      end
      flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
   endtask

   initial begin
      depth = '{4, 5, 2};
      afl   = '{3, 4, 2};
      clear_model();
      test_reset();
      test_fill();
      test_drain();
      test_stream();
      test_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
